// File: rtl/rx_eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_eth_pkg
// Description : Shared types and constants for the rx_eth MII receive path.
//               Holds the frame-parser state encoding, nibble markers, frame
//               length limits, the broadcast address and the CRC-32 constants.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_eth_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        HEADER   = 3'd2,
        PAYLOAD  = 3'd3,
        DROP     = 3'd4
    } state_t;

    localparam logic [3:0]  NIB_PRE     = 4'h5;
    localparam logic [3:0]  NIB_SFD     = 4'hD;

    localparam int          HDR_LEN     = 14;
    localparam int          FCS_LEN     = 4;
    localparam int          MIN_FRAME   = 64;

    localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

    // Reflected CRC-32; the residue is the raw register value left after the
    // FCS itself has been shifted through.
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

endpackage
`default_nettype wire

// File: rtl/rx_crc32_d8.sv
`default_nettype none
// ============================================================================
// Module      : rx_crc32_d8
// Description : Combinational next-state of a reflected CRC-32 for one byte,
//               data consumed LSB first.
// Ports       : crc_in  [31:0] current CRC register
//               data    [7:0]  byte to fold in
//               crc_out [31:0] CRC register after the byte
// Revision    : 1.0 - initial release
// ============================================================================
module rx_crc32_d8
    import rx_eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (w_crc[0] ^ data[i]) begin
                w_crc = (w_crc >> 1) ^ CRC_POLY;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
        crc_out = w_crc;
    end

endmodule
`default_nettype wire

// File: rtl/rx_eth.sv
`default_nettype none
// ============================================================================
// Module      : rx_eth
// Description : Ethernet MII receive front end. Locates preamble/SFD, pairs
//               nibbles into bytes, parses the 14-byte MAC header, optionally
//               filters on destination MAC and streams the payload (FCS
//               stripped) as a byte AXI-Stream without backpressure.
//               Build option: define RX_ETH_CRC_CHECK_EN to check the FCS.
// Ports       : clk, rst (sync, active high)
//               rxd[3:0], rx_dv, rx_er          - PHY MII receive side
//               m_axis_tdata/tvalid/tlast/tuser - payload stream
//               dst_mac, src_mac, eth_type      - last accepted header
//               hdr_valid                       - header accepted pulse
//               frame_cnt, err_cnt              - wrapping frame counters
// Revision    : 1.0 - initial release
// ============================================================================
module rx_eth
    import rx_eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_02_03,
    parameter bit          FILTER_EN = 1'b1,
    parameter int          PRE_MIN   = 7
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] eth_type,
    output logic        hdr_valid,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    state_t          r_state;
    logic [4:0]      r_pre_cnt;
    logic            r_phase;       // 1 = low nibble of current byte held
    logic [3:0]      r_low_nib;
    logic [3:0]      r_hdr_idx;
    logic [6:0]      r_byte_cnt;    // saturating, only compared to MIN_FRAME
    logic            r_err;
    logic [47:0]     r_dst_sh;
    logic [47:0]     r_src_sh;
    logic [7:0]      r_type_hi;
    logic [3:0][7:0] r_line;        // [0] newest, [3] oldest
    logic [2:0]      r_line_cnt;
    logic [7:0]      r_pend;
    logic            r_pend_vld;

    logic [7:0]      w_byte;
    logic            w_dst_ok;
    logic            w_crc_bad;
    logic            w_end_err;

    assign w_byte   = {rxd, r_low_nib};
    assign w_dst_ok = !FILTER_EN || (r_dst_sh == LOCAL_MAC) || (r_dst_sh == BCAST_MAC);

`ifdef RX_ETH_CRC_CHECK_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    rx_crc32_d8 u_crc (
        .crc_in  (r_crc),
        .data    (w_byte),
        .crc_out (w_crc_next)
    );

    // Restarted throughout the preamble so it is fresh at the first dst byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= CRC_INIT;
        end else if (r_state == PREAMBLE) begin
            r_crc <= CRC_INIT;
        end else if ((r_state == HEADER || r_state == PAYLOAD) && rx_dv && r_phase) begin
            r_crc <= w_crc_next;
        end
    end

    assign w_crc_bad = (r_crc != CRC_RESIDUE);
`else
    assign w_crc_bad = 1'b0;
`endif

    // Frame verdict at rx_dv fall: sticky errors, dribble nibble, runt, CRC.
    assign w_end_err = r_err | r_phase | (r_byte_cnt < 7'(MIN_FRAME)) | w_crc_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pre_cnt     <= '0;
            r_phase       <= 1'b0;
            r_low_nib     <= '0;
            r_hdr_idx     <= '0;
            r_byte_cnt    <= '0;
            r_err         <= 1'b0;
            r_dst_sh      <= '0;
            r_src_sh      <= '0;
            r_type_hi     <= '0;
            r_line        <= '0;
            r_line_cnt    <= '0;
            r_pend        <= '0;
            r_pend_vld    <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            dst_mac       <= '0;
            src_mac       <= '0;
            eth_type      <= '0;
            hdr_valid     <= 1'b0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
        end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            hdr_valid     <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (rx_dv) begin
                        if (rxd == NIB_PRE) begin
                            r_state   <= PREAMBLE;
                            r_pre_cnt <= 5'd1;
                        end else begin
                            r_state <= DROP;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!rx_dv) begin
                        r_state <= IDLE;
                    end else if (rxd == NIB_PRE) begin
                        if (r_pre_cnt != 5'h1F) begin
                            r_pre_cnt <= r_pre_cnt + 5'd1;
                        end
                    end else if (rxd == NIB_SFD && r_pre_cnt >= 5'(PRE_MIN)) begin
                        r_state    <= HEADER;
                        r_phase    <= 1'b0;
                        r_hdr_idx  <= '0;
                        r_byte_cnt <= '0;
                        r_err      <= 1'b0;
                        r_line_cnt <= '0;
                        r_pend_vld <= 1'b0;
                    end else begin
                        r_state <= DROP;
                    end
                end

                HEADER: begin
                    if (!rx_dv) begin
                        r_state <= IDLE;
                        err_cnt <= err_cnt + 16'd1;
                    end else begin
                        if (rx_er) begin
                            r_err <= 1'b1;
                        end
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_low_nib <= rxd;
                        end else begin
                            if (r_byte_cnt != 7'h7F) begin
                                r_byte_cnt <= r_byte_cnt + 7'd1;
                            end
                            r_hdr_idx <= r_hdr_idx + 4'd1;
                            if (r_hdr_idx < 4'd6) begin
                                r_dst_sh <= {r_dst_sh[39:0], w_byte};
                            end else if (r_hdr_idx < 4'd12) begin
                                r_src_sh <= {r_src_sh[39:0], w_byte};
                            end else if (r_hdr_idx == 4'd12) begin
                                r_type_hi <= w_byte;
                            end
                            // Last header byte: the shadow copies become visible
                            // only if the frame survives the filter.
                            if (r_hdr_idx == 4'(HDR_LEN - 1)) begin
                                if (w_dst_ok) begin
                                    r_state   <= PAYLOAD;
                                    hdr_valid <= 1'b1;
                                    dst_mac   <= r_dst_sh;
                                    src_mac   <= r_src_sh;
                                    eth_type  <= {r_type_hi, w_byte};
                                end else begin
                                    r_state <= DROP;
                                end
                            end
                        end
                    end
                end

                PAYLOAD: begin
                    if (!rx_dv) begin
                        r_state    <= IDLE;
                        r_pend_vld <= 1'b0;
                        if (r_pend_vld) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= r_pend;
                            m_axis_tlast  <= 1'b1;
                            m_axis_tuser  <= w_end_err;
                            if (w_end_err) begin
                                err_cnt <= err_cnt + 16'd1;
                            end else begin
                                frame_cnt <= frame_cnt + 16'd1;
                            end
                        end else begin
                            err_cnt <= err_cnt + 16'd1;
                        end
                    end else begin
                        if (rx_er) begin
                            r_err <= 1'b1;
                        end
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            // A new byte is starting, so the pending byte cannot
                            // be the last one: release it now.
                            r_low_nib <= rxd;
                            if (r_line_cnt == 3'(FCS_LEN) && r_pend_vld) begin
                                m_axis_tvalid <= 1'b1;
                                m_axis_tdata  <= r_pend;
                                r_pend_vld    <= 1'b0;
                            end
                        end else begin
                            if (r_byte_cnt != 7'h7F) begin
                                r_byte_cnt <= r_byte_cnt + 7'd1;
                            end
                            r_line <= {r_line[2:0], w_byte};
                            if (r_line_cnt == 3'(FCS_LEN)) begin
                                r_pend     <= r_line[3];
                                r_pend_vld <= 1'b1;
                            end else begin
                                r_line_cnt <= r_line_cnt + 3'd1;
                            end
                        end
                    end
                end

                DROP: begin
                    if (!rx_dv) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_eth.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_eth
// Description : Scoreboard bench for rx_eth. Frames are built and their
//               expected beats/headers queued when issued; a monitor pops and
//               compares on every tvalid / hdr_valid. A second instance with
//               the filter disabled shares the same input stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_eth;

    localparam logic [47:0] C_LOCAL = 48'h00_0A_35_01_02_03;
    localparam logic [47:0] C_SRC   = 48'h00_11_22_33_44_55;
    localparam logic [47:0] C_BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] C_OTHER = 48'h02_00_00_00_00_01;
`ifdef RX_ETH_CRC_CHECK_EN
    localparam bit C_CRC_EN = 1'b1;
`else
    localparam bit C_CRC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rxd = 4'h0;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;

    logic [7:0]  tdata,  nf_tdata;
    logic        tvalid, nf_tvalid;
    logic        tlast,  nf_tlast;
    logic        tuser,  nf_tuser;
    logic [47:0] dst_mac, src_mac, nf_dst_mac, nf_src_mac;
    logic [15:0] eth_type, nf_eth_type;
    logic        hdr_valid, nf_hdr_valid;
    logic [15:0] frame_cnt, err_cnt, nf_frame_cnt, nf_err_cnt;

    always #5 clk = ~clk;

    rx_eth #(.LOCAL_MAC(C_LOCAL), .FILTER_EN(1'b1), .PRE_MIN(7)) u_dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
        .m_axis_tuser(tuser), .dst_mac(dst_mac), .src_mac(src_mac),
        .eth_type(eth_type), .hdr_valid(hdr_valid),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    rx_eth #(.LOCAL_MAC(C_LOCAL), .FILTER_EN(1'b0), .PRE_MIN(7)) u_dut_nf (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
        .m_axis_tdata(nf_tdata), .m_axis_tvalid(nf_tvalid), .m_axis_tlast(nf_tlast),
        .m_axis_tuser(nf_tuser), .dst_mac(nf_dst_mac), .src_mac(nf_src_mac),
        .eth_type(nf_eth_type), .hdr_valid(nf_hdr_valid),
        .frame_cnt(nf_frame_cnt), .err_cnt(nf_err_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
    } hdr_t;

    beat_t exp_q[$];
    hdr_t  exp_hq[$];

    int checks = 0;
    int errors = 0;
    int exp_frm = 0, exp_err = 0, nf_frm = 0, nf_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Monitor: every beat / header pulse must match the head of its queue.
    always @(negedge clk) begin
        if (tvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {55'd0, tdata, tlast}, 64'h1FF);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("beat_data", tdata, b.data);
                chk("beat_last", tlast, b.last);
                if (b.last) chk("beat_user", tuser, b.user);
            end
        end
        if (hdr_valid === 1'b1) begin
            if (exp_hq.size() == 0) begin
                chk("unexpected_hdr", eth_type, 16'hFFFF);
            end else begin
                hdr_t h;
                h = exp_hq.pop_front();
                chk("hdr_dst", dst_mac, h.dst);
                chk("hdr_src", src_mac, h.src);
                chk("hdr_type", eth_type, h.typ);
            end
        end
    end

    task automatic drive(input logic [3:0] n, input logic dv, input logic er);
        rxd   = n;
        rx_dv = dv;
        rx_er = er;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_frame_cnt"}, frame_cnt, 16'(exp_frm));
        chk({tag, "_err_cnt"}, err_cnt, 16'(exp_err));
        chk({tag, "_nf_frame_cnt"}, nf_frame_cnt, 16'(nf_frm));
        chk({tag, "_nf_err_cnt"}, nf_err_cnt, 16'(nf_err));
        chk({tag, "_beats_left"}, exp_q.size(), 0);
        chk({tag, "_hdrs_left"}, exp_hq.size(), 0);
    endtask

    // trunc_hdr < 0: full frame; else stop after that many header bytes.
    // rst_at >= 0: pulse rst during the high nibble of that payload byte.
    task automatic send_frame(input logic [47:0] dst, input int plen, input int pre_n,
                              input int er_byte, input bit bad_fcs, input int trunc_hdr,
                              input int rst_at, input int gap);
        logic [7:0]  fr [0:127];
        logic [31:0] c;
        logic [7:0]  bv;
        int          flen, nbytes;
        bit          dst_ok, ferr, er;
        hdr_t        h;
        beat_t       b;

        for (int i = 0; i < 6; i++) begin
            fr[i]     = dst[47 - 8*i -: 8];
            fr[6 + i] = C_SRC[47 - 8*i -: 8];
        end
        fr[12] = 8'h08;
        fr[13] = 8'h00;
        for (int i = 0; i < plen; i++) fr[14 + i] = i[7:0];
        flen = 14 + plen;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < flen; i++) c = crc_upd(c, fr[i]);
        c = ~c;
        fr[flen]     = c[7:0];
        fr[flen + 1] = c[15:8];
        fr[flen + 2] = c[23:16];
        fr[flen + 3] = c[31:24];
        flen = flen + 4;
        if (bad_fcs) fr[flen - 1] = fr[flen - 1] ^ 8'h01;

        dst_ok = (dst == C_LOCAL) || (dst == C_BCAST);
        ferr   = (er_byte >= 0) || (flen < 64) || (bad_fcs && C_CRC_EN);
        h.dst  = dst;
        h.src  = C_SRC;
        h.typ  = 16'h0800;

        if (pre_n >= 7) begin
            if (trunc_hdr >= 0) begin
                exp_err++;
                nf_err++;
            end else if (rst_at >= 0) begin
                if (dst_ok) begin
                    exp_hq.push_back(h);
                    for (int k = 0; k <= rst_at - 5; k++) begin
                        b.data = k[7:0]; b.last = 1'b0; b.user = 1'b0;
                        exp_q.push_back(b);
                    end
                end
            end else begin
                if (dst_ok) begin
                    exp_hq.push_back(h);
                    for (int k = 0; k < plen; k++) begin
                        b.data = k[7:0]; b.last = (k == plen - 1); b.user = ferr;
                        exp_q.push_back(b);
                    end
                    if (plen > 0 && !ferr) exp_frm++; else exp_err++;
                end
                if (plen > 0 && !ferr) nf_frm++; else nf_err++;
            end
        end

        for (int n = 0; n < pre_n; n++) drive(4'h5, 1'b1, 1'b0);
        drive(4'hD, 1'b1, 1'b0);
        nbytes = (trunc_hdr >= 0) ? trunc_hdr : flen;
        for (int j = 0; j < nbytes; j++) begin
            bv = fr[j];
            er = (er_byte >= 0) && (j == 14 + er_byte);
            drive(bv[3:0], 1'b1, er);
            if (rst_at >= 0 && j == 14 + rst_at) begin
                rst = 1'b1;
                drive(bv[7:4], 1'b1, er);
                rst = 1'b0;
                chk("rst_tvalid", tvalid, 1'b0);
                chk("rst_frame_cnt", frame_cnt, 16'd0);
                chk("rst_err_cnt", err_cnt, 16'd0);
                exp_frm = 0; exp_err = 0; nf_frm = 0; nf_err = 0;
            end else begin
                drive(bv[7:4], 1'b1, er);
            end
        end
        for (int g = 0; g < gap; g++) drive(4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_tvalid", tvalid, 1'b0);
        chk("reset_hdr_valid", hdr_valid, 1'b0);
        chk("reset_eth_type", eth_type, 16'h0);
        chk("reset_dst_mac", dst_mac, 48'h0);
        check_state("reset");

        send_frame(C_LOCAL, 46, 7, -1, 1'b0, -1, -1, 4);
        check_state("good");
        chk("good_eth_type", eth_type, 16'h0800);

        send_frame(C_OTHER, 46, 7, -1, 1'b0, -1, -1, 4);
        check_state("filtered");

        send_frame(C_BCAST, 46, 7, 10, 1'b0, -1, -1, 4);
        check_state("rx_er");

        send_frame(C_LOCAL, 46, 7, -1, 1'b1, -1, -1, 4);
        check_state("bad_fcs");

        send_frame(C_LOCAL, 46, 7, -1, 1'b0, 9, -1, 1);
        send_frame(C_LOCAL, 46, 7, -1, 1'b0, -1, -1, 4);
        check_state("trunc_then_good");

        send_frame(C_LOCAL, 10, 9, -1, 1'b0, -1, -1, 4);
        check_state("runt");

        send_frame(C_LOCAL, 0, 7, -1, 1'b0, -1, -1, 4);
        check_state("empty_payload");

        send_frame(C_LOCAL, 46, 7, -1, 1'b0, -1, 20, 4);
        check_state("mid_rst");

        send_frame(C_BCAST, 50, 7, -1, 1'b0, -1, -1, 1);
        send_frame(C_LOCAL, 46, 7, -1, 1'b0, -1, -1, 4);
        check_state("after_rst");

        send_frame(C_BCAST, 46, 5, -1, 1'b0, -1, -1, 4);
        check_state("short_preamble");
        chk("hold_dst_mac", dst_mac, C_LOCAL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
